sync_fifo: RTL
==============

# sync_fifo

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock FIFO, used where producer and consumer share a clock. Generalises depth to any power of two. Adds a registered occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time first-word-fall-through (FWFT) read mode is also available. Sits between datapath stages in the AXI/DDR pipeline as an elastic buffer.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 7, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 128)
- AFULL_THRESH, DEPTH-4, almost_full asserts when count >= AFULL_THRESH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= AEMPTY_THRESH

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (standard) / pop (FWFT)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data qualifier
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_THRESH
- empty  out  1  count == 0
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears overflow/underflow
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit and the low bits address memory. count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1), held in a register.
- Write accept: wr_en && !full. Memory writes wr_data at wr_ptr, then wr_ptr increments.
- Read accept: rd_en && !empty. rd_ptr increments.
- Decisions use the registered state at the edge. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags decode combinationally from registered count; no other logic sits in the path.
- Overflow sets on wr_en && full. Underflow sets on rd_en && empty. Both clear on err_clr. If set and clear occur in the same cycle, set wins.
- Pointer wrap is natural binary roll-over. Full and empty are never ambiguous because count is explicit.

## Timing
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0.
- Asserting rstn low mid-operation discards all contents immediately. Memory contents are not cleared.
- Write to flags/count latency: 1 cycle. empty deasserts on the edge that accepts the first write.
- Standard read latency: rd_data and rd_valid register on the accepting edge. rd_valid is a one-cycle pulse per accepted read. rd_data holds its last value otherwise.
- Back-to-back reads sustain 1 word/cycle. Simultaneous read+write sustains 1 word/cycle at any occupancy except the rejected cases above.

## Configuration
- SYNC_FIFO_FWFT_EN defined: FWFT mode.
  - rd_data = mem[rd_ptr] combinationally.
  - rd_valid = !empty.
  - rd_en acts as a pop acknowledge.
  - A word written to an empty FIFO is visible on rd_data one cycle after the write edge.
- Not defined: standard registered-read mode as above.

## Structure
- Package sync_fifo_pkg holds the default parameter constants (DATA_WIDTH, ADDR_WIDTH, margin 4) and the ptr_t/count_t width helpers.
- One sub-module, sync_fifo_mem: simple dual-port RAM with registered write and, per mode, a registered or asynchronous read port. Pointer, count and flag logic stay in sync_fifo.

## Test plan
- Reset then 128 writes of 0..127 with no reads → full=1 and count=128. almost_full first rises when count reaches 124. A 129th write sets overflow, and count stays 128.
- Drain 128 reads → data 0..127 in order. rd_valid pulses one cycle after each read (standard mode). empty=1 after the last read, and almost_empty rises when count reaches 4.
- Read on empty with simultaneous wr_en (wr_data=0xA5A5A5A5) → underflow=1, count=1. The next read returns 0xA5A5A5A5.
- Hold count=64, then 1000 cycles of random simultaneous wr_en/rd_en both high → count stays 64, order preserved across pointer wrap.
- Overflow set and err_clr pulsed in the same cycle as a new overflow → overflow stays 1. A subsequent lone err_clr → overflow=0.
- With SYNC_FIFO_FWFT_EN: write 0x11 to empty → rd_valid=1 and rd_data=0x11 in the next cycle without rd_en. rstn pulsed mid-burst → empty=1, rd_valid=0, count=0 immediately.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - default geometry constants and pointer/count width helpers for sync_fifo
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int THRESH_MARGIN      = 4;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Occupancy spans 0..DEPTH inclusive, so it needs the same extra bit.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;
    typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port RAM; read port registered, or asynchronous under SYNC_FIFO_FWFT_EN
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array is never reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; pops only move the address.
    assign rd_data = mem[rd_addr];

    logic unused_rd_ctrl;
    assign unused_rd_ctrl = &{1'b0, rd_en, rstn};
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Output register loads only on an accepted read and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count, thresholds and sticky errors; SYNC_FIFO_FWFT_EN selects FWFT reads
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - THRESH_MARGIN,
    parameter int AEMPTY_THRESH = THRESH_MARGIN
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_CNT    = CW'(1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          wr_accept;
    logic          rd_accept;
    logic          overflow_q;
    logic          underflow_q;

    // Acceptance looks only at registered flags, so a full FIFO rejects a
    // write even when a read drains a slot in the same cycle (and vice versa).
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Flags are pure decodes of the registered count.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign count        = count_q;

    // Pointers roll over naturally; the wrap bit never needs special handling
    // because full/empty come from the explicit count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
        end
    end

    // Occupancy tracks wr_ptr - rd_ptr; simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // The wrap bits only matter for the pointer difference, which the count
    // register already carries.
    logic unused_wrap_bits;
    assign unused_wrap_bits = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The head word is valid whenever anything is stored.
    assign rd_valid = !empty;
`else
    logic rd_valid_q;

    // One-cycle qualifier aligned with the registered read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

endmodule
